// File: rtl/ptm_pkg.sv
// PTM encoder shared definitions: packet header constants, FSM states,
// byte-count type and the branch address-field helper.
package ptm_pkg;

    localparam logic [7:0] ASYNC_ZERO = 8'h00;
    localparam logic [7:0] ASYNC_END  = 8'h80;
    localparam logic [7:0] ISYNC_HDR  = 8'h08;
    localparam logic [7:0] ISYNC_INFO = 8'h00;

    // header + four address bytes + info byte, before the context ID
    localparam int ISYNC_FIXED = 6;

    localparam int BR_HDR_BIT  = 0;
    localparam int BR_CONT_BIT = 7;
    localparam int BR_MODE_BIT = 4;

    typedef logic [2:0] nbytes_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASYNC,
        ST_ISYNC,
        ST_BRANCH
    } state_t;

    // a = addr[31:1]; ARM drops one more low bit
    function automatic logic [30:0] addr_field(
        input logic [30:0] a,
        input logic        thumb
    );
        return thumb ? a : {1'b0, a[30:1]};
    endfunction

endpackage

// File: rtl/ptm_encoder_if.sv
// Branch-request and trace-byte handshake bundle for the PTM encoder.
// master = capture logic / byte sink, slave = encoder.
interface ptm_encoder_if #(
    parameter int CONTEXTID_LEN = 4
);

    logic                       iBranchEn;
    logic                       oBranchReady;
    logic [31:0]                iBranchAddr;
    logic                       iThumb;
    logic [8*CONTEXTID_LEN-1:0] iContextId;
    logic                       iSyncReq;
    logic [7:0]                 oData;
    logic                       oDataEn;
    logic                       iReady;

    modport master (
        output iBranchEn,
        output iBranchAddr,
        output iThumb,
        output iContextId,
        output iSyncReq,
        output iReady,
        input  oBranchReady,
        input  oData,
        input  oDataEn
    );

    modport slave (
        input  iBranchEn,
        input  iBranchAddr,
        input  iThumb,
        input  iContextId,
        input  iSyncReq,
        input  iReady,
        output oBranchReady,
        output oData,
        output oDataEn
    );

endinterface

// File: rtl/ptm_branch_compress.sv
// Branch address compression: picks the shortest packet that carries every
// changed address bit and builds all five candidate bytes.
module ptm_branch_compress
    import ptm_pkg::*;
(
    input  logic [30:0]      s,
    input  logic [30:0]      lo,
    input  logic             thumb,
    input  logic             last_thumb,
    input  logic [3:0]       addr_hi,
    output nbytes_t          n,
    output logic [4:0][7:0]  bytes
);

    logic [30:0] diff;

    // byte count and candidate bytes
    always_comb begin
        diff = s ^ lo;
        n    = 3'd5;
        if (thumb == last_thumb) begin
            if (diff[30:6] == '0) begin
                n = 3'd1;
            end else if (diff[30:12] == '0) begin
                n = 3'd2;
            end else if (diff[30:19] == '0) begin
                n = 3'd3;
            end else if (diff[30:26] == '0) begin
                n = 3'd4;
            end
        end

        bytes[0]              = {1'b0, s[5:0], 1'b0};
        bytes[0][BR_HDR_BIT]  = 1'b1;
        bytes[0][BR_CONT_BIT] = (n != 3'd1);

        bytes[1] = (n == 3'd2) ? {2'b00, s[11:6]} : {1'b0, s[12:6]};
        bytes[1][BR_CONT_BIT] = (n != 3'd2);

        bytes[2] = (n == 3'd3) ? {2'b00, s[18:13]} : {1'b0, s[19:13]};
        bytes[2][BR_CONT_BIT] = (n != 3'd3);

        bytes[3] = (n == 3'd4) ? {2'b00, s[25:20]} : {1'b0, s[26:20]};
        bytes[3][BR_CONT_BIT] = (n != 3'd4);

        bytes[4] = thumb ? {4'b0000, addr_hi} : {5'b00000, addr_hi[3:1]};
        bytes[4][BR_MODE_BIT] = thumb;
    end

endmodule

// File: rtl/ptm_encoder.sv
// PTM trace encoder: emits A-sync, I-sync and compressed branch packets.
// Optional PTM_ENC_PERIODIC_SYNC_EN forces a re-sync every SYNC_PERIOD bytes.
module ptm_encoder
    import ptm_pkg::*;
#(
    parameter int CONTEXTID_LEN = 4,
    parameter int ASYNC_ZEROS   = 5
`ifdef PTM_ENC_PERIODIC_SYNC_EN
    ,
    parameter int SYNC_PERIOD   = 1024
`endif
) (
    input logic          iClk,
    input logic          iRst,
    ptm_encoder_if.slave bus
);

    localparam logic [7:0] ASYNC_LAST = 8'(ASYNC_ZEROS);
    localparam logic [7:0] ISYNC_LAST = 8'(ISYNC_FIXED + CONTEXTID_LEN - 1);

    state_t                     state;
    logic [7:0]                 idx;
    logic                       sync_pend;
    logic [31:1]                last_addr;
    logic                       last_thumb;
    logic [8*CONTEXTID_LEN-1:0] cur_ctx;
    logic [4:0][7:0]            pkt;
    nbytes_t                    pkt_n;

    logic            out_free;
    logic            accept;
    logic            sync_hit;
    logic [30:0]     s_new;
    logic [30:0]     s_lo;
    nbytes_t         cmp_n;
    logic [4:0][7:0] cmp_bytes;
    logic [7:0]      nxt_byte;
    logic            nxt_last;

    assign out_free         = !bus.oDataEn || bus.iReady;
    assign bus.oBranchReady = !iRst && (state == ST_IDLE) && out_free;
    assign accept           = bus.iBranchEn && bus.oBranchReady;
    assign s_new            = addr_field(bus.iBranchAddr[31:1], bus.iThumb);
    assign s_lo             = addr_field(last_addr, bus.iThumb);

    ptm_branch_compress u_cmp (
        .s          (s_new),
        .lo         (s_lo),
        .thumb      (bus.iThumb),
        .last_thumb (last_thumb),
        .addr_hi    (bus.iBranchAddr[31:28]),
        .n          (cmp_n),
        .bytes      (cmp_bytes)
    );

`ifdef PTM_ENC_PERIODIC_SYNC_EN
    logic [15:0] sync_cnt;

    assign sync_hit = bus.oDataEn && bus.iReady
                   && (sync_cnt == 16'(SYNC_PERIOD - 1));

    // count bytes taken by the sink; wrap on each forced re-sync
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_cnt <= '0;
        end else if (bus.oDataEn && bus.iReady) begin
            sync_cnt <= sync_hit ? '0 : sync_cnt + 16'd1;
        end
    end
`else
    assign sync_hit = 1'b0;
`endif

    // select the byte the current state emits at the current index
    always_comb begin
        nxt_byte = 8'h00;
        nxt_last = 1'b0;
        case (state)
            ST_ASYNC: begin
                nxt_last = (idx == ASYNC_LAST);
                nxt_byte = nxt_last ? ASYNC_END : ASYNC_ZERO;
            end
            ST_ISYNC: begin
                nxt_last = (idx == ISYNC_LAST);
                case (idx)
                    8'd0:    nxt_byte = ISYNC_HDR;
                    8'd1:    nxt_byte = {last_addr[7:1], last_thumb};
                    8'd2:    nxt_byte = last_addr[15:8];
                    8'd3:    nxt_byte = last_addr[23:16];
                    8'd4:    nxt_byte = last_addr[31:24];
                    8'd5:    nxt_byte = ISYNC_INFO;
                    default: begin
                        for (int i = 0; i < CONTEXTID_LEN; i++) begin
                            if (idx == 8'(ISYNC_FIXED + i)) begin
                                nxt_byte = cur_ctx[8*i +: 8];
                            end
                        end
                    end
                endcase
            end
            ST_BRANCH: begin
                nxt_last = (idx == ({5'b0, pkt_n} - 8'd1));
                for (int i = 0; i < 5; i++) begin
                    if (idx == 8'(i)) begin
                        nxt_byte = pkt[i];
                    end
                end
            end
            default: begin
                nxt_byte = 8'h00;
                nxt_last = 1'b0;
            end
        endcase
    end

    // packet FSM, output register and sync-pending flag
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sync_pend   <= 1'b1;
            last_addr   <= '0;
            last_thumb  <= 1'b0;
            cur_ctx     <= '0;
            pkt         <= '0;
            pkt_n       <= 3'd1;
            bus.oData   <= 8'h00;
            bus.oDataEn <= 1'b0;
        end else begin
            if (out_free) begin
                if (state == ST_IDLE) begin
                    bus.oDataEn <= 1'b0;
                    if (accept) begin
                        last_addr  <= bus.iBranchAddr[31:1];
                        last_thumb <= bus.iThumb;
                        cur_ctx    <= bus.iContextId;
                        pkt        <= cmp_bytes;
                        pkt_n      <= cmp_n;
                        idx        <= '0;
                        state      <= (sync_pend || bus.iSyncReq)
                                    ? ST_ASYNC : ST_BRANCH;
                    end
                end else begin
                    bus.oData   <= nxt_byte;
                    bus.oDataEn <= 1'b1;
                    if (nxt_last) begin
                        idx   <= '0;
                        state <= (state == ST_ASYNC) ? ST_ISYNC : ST_IDLE;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
            end

            // an accept consumes any pending request; a request seen
            // during a packet waits for the next accept
            if (accept) begin
                sync_pend <= sync_hit;
            end else begin
                sync_pend <= sync_pend || bus.iSyncReq || sync_hit;
            end
        end
    end

endmodule

// File: tb/tb_ptm_encoder.sv
// Scoreboard bench for ptm_encoder: directed branches with hand-computed
// byte streams, back-pressure, sync requests and mid-packet reset.
module tb_ptm_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    ptm_encoder_if #(.CONTEXTID_LEN(4)) bus ();

    ptm_encoder #(
        .CONTEXTID_LEN (4),
        .ASYNC_ZEROS   (5)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // monitor: every byte the sink takes must be the next expected byte
    always @(negedge clk) begin
        if (!rst && bus.oDataEn && bus.iReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte got=%h want=none", bus.oData);
            end else begin
                chk("byte", {24'h0, bus.oData}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_n(input int n, input logic [39:0] v);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic push_sync(input logic [31:0] a, input logic t,
                             input logic [31:0] ctx);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h08);
        exp_q.push_back({a[7:1], t});
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[31:24]);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(ctx[8*i +: 8]);
    endtask

    task automatic send(input logic [31:0] a, input logic t,
                        input logic [31:0] ctx, input logic sync);
        int g = 0;
        @(negedge clk);
        bus.iBranchEn   = 1'b1;
        bus.iBranchAddr = a;
        bus.iThumb      = t;
        bus.iContextId  = ctx;
        bus.iSyncReq    = sync;
        while (!bus.oBranchReady && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("accept", {31'h0, bus.oBranchReady}, 32'h1);
        @(posedge clk);
        #1;
        bus.iBranchEn = 1'b0;
        bus.iSyncReq  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("idle_en", {31'h0, bus.oDataEn}, 32'h0);
        chk("idle_ready", {31'h0, bus.oBranchReady}, 32'h1);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!(bus.oDataEn && bus.oData == b) && g < 100);
        chk("wait_byte", {24'h0, bus.oData}, {24'h0, b});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.iBranchEn   = 1'b0;
        bus.iBranchAddr = '0;
        bus.iThumb      = 1'b0;
        bus.iContextId  = '0;
        bus.iSyncReq    = 1'b0;
        bus.iReady      = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_en", {31'h0, bus.oDataEn}, 32'h0);
        chk("rst_ready", {31'h0, bus.oBranchReady}, 32'h0);
        chk("rst_data", {24'h0, bus.oData}, 32'h0);
        rst = 1'b0;

        // 1: first accept after reset is a full sync
        push_sync(32'h0000_1000, 1'b0, 32'h1122_3344);
        send(32'h0000_1000, 1'b0, 32'h1122_3344, 1'b0);
        drain();

        // 2: single-byte branch
        push_n(1, 40'h09);
        send(32'h0000_1010, 1'b0, 32'h0, 1'b0);
        drain();

        // 3: two-byte branch, sink stalls on the second byte
        push_n(2, 40'h81_20);
        send(32'h0000_2000, 1'b0, 32'h0, 1'b0);
        wait_byte(8'h20);
        bus.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_data", {24'h0, bus.oData}, 32'h20);
            chk("hold_en", {31'h0, bus.oDataEn}, 32'h1);
            chk("hold_ready", {31'h0, bus.oBranchReady}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.iReady = 1'b1;
        drain();

        // 4: Thumb mode change, sync request during byte 2
        push_n(5, 40'h83_C0_80_80_10);
        send(32'h0000_2002, 1'b1, 32'h0, 1'b0);
        wait_byte(8'hC0);
        bus.iSyncReq = 1'b1;
        @(posedge clk);
        #1;
        bus.iSyncReq = 1'b0;
        drain();

        // pending sync is honoured at the next accept
        push_sync(32'h0000_2004, 1'b1, 32'hA1B2_C3D4);
        send(32'h0000_2004, 1'b1, 32'hA1B2_C3D4, 1'b0);
        drain();

        // ARM five-byte (mode change), then n=3, n=4, n=5, bit-12 edge
        push_n(5, 40'h85_A0_80_80_00);
        send(32'h0000_2008, 1'b0, 32'h0, 1'b0);
        push_n(3, 40'h85_A0_10);
        send(32'h0008_2008, 1'b0, 32'h0, 1'b0);
        push_n(4, 40'h85_A0_90_10);
        send(32'h0408_2008, 1'b0, 32'h0, 1'b0);
        push_n(5, 40'h85_A0_90_90_04);
        send(32'h8408_2008, 1'b0, 32'h0, 1'b0);
        push_n(3, 40'h85_E0_10);
        send(32'h8408_6008, 1'b0, 32'h0, 1'b0);
        drain();

        // reset mid-packet: byte held, then abandoned
        bus.iReady = 1'b0;
        send(32'h0000_0000, 1'b0, 32'h0, 1'b0);
        wait_byte(8'h81);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_en", {31'h0, bus.oDataEn}, 32'h0);
        chk("mrst_ready", {31'h0, bus.oBranchReady}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.iReady = 1'b1;

        push_sync(32'h0000_1000, 1'b0, 32'h1122_3344);
        send(32'h0000_1000, 1'b0, 32'h1122_3344, 1'b0);
        drain();

        // sync request coincident with accept
        push_sync(32'h0000_1010, 1'b0, 32'h5566_7788);
        send(32'h0000_1010, 1'b0, 32'h5566_7788, 1'b1);
        drain();

        // same address again: one byte, no sync
        push_n(1, 40'h09);
        send(32'h0000_1010, 1'b0, 32'h0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
